// File: rtl/sniffer_pkg.sv
// ---------------------------------------------------------------------------
// sniffer_pkg
// Shared types for the compare window feeder and its window FIFO.
//   feeder_state_t : packet tracking FSM states
//   WIN_BYTES      : bytes per comparator window (fixed at 4)
//   win_entry_t    : one queued window (data, last flag, optional byte offset)
// Optional feature macro: FEEDER_BYTE_OFFSET_EN adds the offset field.
// ---------------------------------------------------------------------------
package sniffer_pkg;

  localparam int WIN_BYTES = 4;
  localparam int WIN_W     = 32;
  localparam int OFF_W     = 16;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    STREAM
  } feeder_state_t;

  typedef struct packed {
    logic [WIN_W-1:0] data;
    logic             last;
`ifdef FEEDER_BYTE_OFFSET_EN
    logic [OFF_W-1:0] offset;
`endif
  } win_entry_t;

endpackage

// File: rtl/compare_window_feeder_if.sv
// ---------------------------------------------------------------------------
// compare_window_feeder_if
// Window handshake between the feeder (master) and the comparator (slave).
//   data_in    : 32-bit window, newest byte in [7:0]
//   win_valid  : data_in / win_last (/ win_offset) valid
//   win_ready  : comparator accepts when win_valid && win_ready
//   win_last   : final window of a packet
//   win_offset : (FEEDER_BYTE_OFFSET_EN only) packet index of newest byte
// ---------------------------------------------------------------------------
interface compare_window_feeder_if;

  logic [31:0] data_in;
  logic        win_valid;
  logic        win_ready;
  logic        win_last;
`ifdef FEEDER_BYTE_OFFSET_EN
  logic [15:0] win_offset;
`endif

  modport master (
`ifdef FEEDER_BYTE_OFFSET_EN
    output win_offset,
`endif
    output data_in,
    output win_valid,
    output win_last,
    input  win_ready
  );

  modport slave (
`ifdef FEEDER_BYTE_OFFSET_EN
    input  win_offset,
`endif
    input  data_in,
    input  win_valid,
    input  win_last,
    output win_ready
  );

endinterface

// File: rtl/compare_window_feeder_window_fifo.sv
// ---------------------------------------------------------------------------
// window_fifo
// Small synchronous FIFO of win_entry_t. Head entry is presented
// combinationally from the storage array (first-word fall-through).
//   clk, rst   : clock, synchronous active-high reset (flushes pointers)
//   push       : write push_entry (ignored when full unless popping too)
//   push_entry : entry to write
//   pop        : remove head (ignored when empty)
//   head       : current head entry (meaningful only when !empty)
//   full/empty : occupancy flags
// Pointers carry one extra wrap bit: full when wrap bits differ and the
// index bits match, empty when the pointers are identical.
// ---------------------------------------------------------------------------
module window_fifo
  import sniffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  win_entry_t push_entry,
  input  logic       pop,
  output win_entry_t head,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  win_entry_t  mem_q [DEPTH];

  logic do_pop;
  logic do_push;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

  // A pop frees the slot at the same edge, so push+pop on a full FIFO works:
  // when full the write slot equals the read slot, and the head is read
  // before the edge overwrites it.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign head = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q + {{AW{1'b0}}, do_push};
    rd_d = rd_q + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage needs no reset: nothing is read until a push has filled it.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q[AW-1:0]] <= push_entry;
    end
  end

endmodule

// File: rtl/compare_window_feeder.sv
// ---------------------------------------------------------------------------
// compare_window_feeder
// Turns the receive byte stream into sliding 32-bit windows (newest byte in
// [7:0]), queues them in window_fifo and hands them to the comparator over
// a valid/ready handshake with a last flag at packet end.
// Parameters: FIFO_DEPTH (power of 2, >=2), WIN_BYTES (must be 4).
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   byte_in/byte_valid            : received byte, never stalled
//   byte_sop/byte_eop             : packet start/end marks (qualify byte_valid)
//   win (compare_window_feeder_if.master) : window handshake to comparator
//   overflow                      : sticky, a window was dropped on full FIFO
//   ovf_clr                       : clears overflow (a same-cycle drop wins)
// Optional feature: define FEEDER_BYTE_OFFSET_EN to add win.win_offset, the
// saturating packet byte index of the newest byte in each window.
// ---------------------------------------------------------------------------
module compare_window_feeder
  import sniffer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int WIN_BYTES  = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [7:0]                     byte_in,
  input  logic                           byte_valid,
  input  logic                           byte_sop,
  input  logic                           byte_eop,
  compare_window_feeder_if.master        win,
  output logic                           overflow,
  input  logic                           ovf_clr
);

  if (WIN_BYTES != sniffer_pkg::WIN_BYTES) begin : g_bad_win_bytes
    $error("compare_window_feeder: WIN_BYTES must be 4");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("compare_window_feeder: FIFO_DEPTH must be a power of 2 >= 2");
  end

  // Only the previous three bytes are kept: the outgoing window is always
  // {shreg_q, byte_in}, so the oldest byte never needs storage.
  feeder_state_t state_q, state_d;
  logic [23:0]   shreg_q, shreg_d;
  logic [2:0]    fill_q, fill_d;       // bytes seen in packet, saturates at 4
  logic          push_q, push_d;       // registered push keeps latency at one edge
  win_entry_t    push_entry_q, push_entry_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   hold_data_q, hold_data_d;
`ifdef FEEDER_BYTE_OFFSET_EN
  logic [15:0]   idx_q, idx_d;
  logic [15:0]   hold_off_q, hold_off_d;
`endif

  logic          take;
  logic [31:0]   window;
  win_entry_t    head;
  logic          full;
  logic          empty;
  logic          pop;
  logic          drop;

  // Non-sop bytes outside a packet are ignored.
  assign take   = byte_valid && (byte_sop || (state_q != IDLE));
  assign window = byte_sop ? {24'h0, byte_in} : {shreg_q, byte_in};

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    fill_d       = fill_q;
    push_d       = 1'b0;
    push_entry_d = '0;
`ifdef FEEDER_BYTE_OFFSET_EN
    idx_d        = idx_q;
`endif
    if (take) begin
      shreg_d = window[23:0];
      if (byte_sop) begin
        fill_d = 3'd1;
      end else if (fill_q < 3'd4) begin
        fill_d = fill_q + 3'd1;
      end
`ifdef FEEDER_BYTE_OFFSET_EN
      if (byte_sop) begin
        idx_d = 16'h0;
      end else if (idx_q != 16'hFFFF) begin
        idx_d = idx_q + 16'h1;
      end
      push_entry_d.offset = idx_d;
`endif
      // Short packets reach eop with zeros still in the upper bytes, which
      // gives the left zero padding for free.
      push_d            = byte_eop || (fill_d == 3'd4);
      push_entry_d.data = window;
      push_entry_d.last = byte_eop;
      if (byte_eop) begin
        state_d = IDLE;
      end else if (fill_d == 3'd4) begin
        state_d = STREAM;
      end else begin
        state_d = FILL;
      end
    end
  end

  assign pop  = win.win_valid && win.win_ready;
  assign drop = push_q && full && !pop;

  always_comb begin
    ovf_d       = ovf_q;
    hold_data_d = hold_data_q;
`ifdef FEEDER_BYTE_OFFSET_EN
    hold_off_d  = hold_off_q;
`endif
    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (pop) begin
      hold_data_d = head.data;
`ifdef FEEDER_BYTE_OFFSET_EN
      hold_off_d  = head.offset;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      fill_q       <= '0;
      push_q       <= 1'b0;
      push_entry_q <= '0;
      ovf_q        <= 1'b0;
      hold_data_q  <= '0;
`ifdef FEEDER_BYTE_OFFSET_EN
      idx_q        <= '0;
      hold_off_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      fill_q       <= fill_d;
      push_q       <= push_d;
      push_entry_q <= push_entry_d;
      ovf_q        <= ovf_d;
      hold_data_q  <= hold_data_d;
`ifdef FEEDER_BYTE_OFFSET_EN
      idx_q        <= idx_d;
      hold_off_q   <= hold_off_d;
`endif
    end
  end

  window_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push_q),
    .push_entry (push_entry_q),
    .pop        (pop),
    .head       (head),
    .full       (full),
    .empty      (empty)
  );

  // When empty the last delivered window stays on data_in.
  assign win.win_valid = !empty;
  assign win.data_in   = empty ? hold_data_q : head.data;
  assign win.win_last  = !empty && head.last;
`ifdef FEEDER_BYTE_OFFSET_EN
  assign win.win_offset = empty ? hold_off_q : head.offset;
`endif
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_compare_window_feeder.sv
// ---------------------------------------------------------------------------
// tb_compare_window_feeder
// Directed bench for compare_window_feeder (FIFO_DEPTH=4). Windows accepted
// by the comparator side are recorded and compared against hand-computed
// values. Optional offset checks are built when FEEDER_BYTE_OFFSET_EN is set.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_compare_window_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_sop;
  logic       byte_eop;
  logic       overflow;
  logic       ovf_clr;

  always #5 clk = ~clk;

  compare_window_feeder_if win_if ();

  compare_window_feeder #(
    .FIFO_DEPTH (4),
    .WIN_BYTES  (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_sop   (byte_sop),
    .byte_eop   (byte_eop),
    .win        (win_if),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr)
  );

  int check_cnt = 0;
  int pass_cnt  = 0;

  logic [31:0] got_data[$];
  logic        got_last[$];
  logic [15:0] got_off[$];

  // Record every window the comparator side accepts (pop on next posedge).
  always @(negedge clk) begin
    if (!rst && win_if.win_valid && win_if.win_ready) begin
      got_data.push_back(win_if.data_in);
      got_last.push_back(win_if.win_last);
`ifdef FEEDER_BYTE_OFFSET_EN
      got_off.push_back(win_if.win_offset);
`else
      got_off.push_back(16'h0);
`endif
      $display("window accepted: data=%h last=%0b", win_if.data_in, win_if.win_last);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic s, input logic e);
    byte_in    = b;
    byte_valid = 1'b1;
    byte_sop   = s;
    byte_eop   = e;
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    byte_sop   = 1'b0;
    byte_eop   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_got();
    got_data.delete();
    got_last.delete();
    got_off.delete();
  endtask

  task automatic expect_win(input string tag, input int i, input logic [31:0] d, input logic l);
    check({tag, "_data"}, (i < got_data.size()) ? got_data[i] : 32'hxxxx_xxxx, d);
    check({tag, "_last"}, (i < got_last.size()) ? {31'b0, got_last[i]} : 32'hxxxx_xxxx, {31'b0, l});
  endtask

  initial begin
    rst        = 1'b1;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    byte_sop   = 1'b0;
    byte_eop   = 1'b0;
    ovf_clr    = 1'b0;
    win_if.win_ready = 1'b0;

    // 1: reset
    idle(2);
    check("rst_valid", {31'b0, win_if.win_valid}, 32'd0);
    check("rst_data", win_if.data_in, 32'h0);
    check("rst_last", {31'b0, win_if.win_last}, 32'd0);
    check("rst_ovf", {31'b0, overflow}, 32'd0);
    rst = 1'b0;
    idle(1);

    // 2: 5-byte packet, latency and sliding windows
    win_if.win_ready = 1'b1;
    clear_got();
    send(8'h11, 1'b1, 1'b0);
    send(8'h22, 1'b0, 1'b0);
    send(8'h33, 1'b0, 1'b0);
    send(8'h44, 1'b0, 1'b0);
    check("t2_not_yet_valid", {31'b0, win_if.win_valid}, 32'd0);
    send(8'h55, 1'b0, 1'b1);
    check("t2_first_valid", {31'b0, win_if.win_valid}, 32'd1);
    check("t2_first_data", win_if.data_in, 32'h11223344);
    idle(4);
    check("t2_count", got_data.size(), 32'd2);
    expect_win("t2_w0", 0, 32'h11223344, 1'b0);
    expect_win("t2_w1", 1, 32'h22334455, 1'b1);
`ifdef FEEDER_BYTE_OFFSET_EN
    check("t2_off0", {16'b0, got_off[0]}, 32'd3);
    check("t2_off1", {16'b0, got_off[1]}, 32'd4);
`endif

    // 3: short packet and sop+eop single byte
    clear_got();
    send(8'hAA, 1'b1, 1'b0);
    send(8'hBB, 1'b0, 1'b1);
    idle(3);
    send(8'h7E, 1'b1, 1'b1);
    idle(3);
    check("t3_count", got_data.size(), 32'd2);
    expect_win("t3_short", 0, 32'h0000AABB, 1'b1);
    expect_win("t3_single", 1, 32'h0000007E, 1'b1);
`ifdef FEEDER_BYTE_OFFSET_EN
    check("t3_off0", {16'b0, got_off[0]}, 32'd1);
    check("t3_off1", {16'b0, got_off[1]}, 32'd0);
`endif

    // 4: stall, overflow, clear, release in order
    win_if.win_ready = 1'b0;
    clear_got();
    send(8'h01, 1'b1, 1'b0);
    send(8'h02, 1'b0, 1'b0);
    send(8'h03, 1'b0, 1'b0);
    send(8'h04, 1'b0, 1'b0);
    send(8'h05, 1'b0, 1'b0);
    check("t4_stall_data5", win_if.data_in, 32'h01020304);
    send(8'h06, 1'b0, 1'b0);
    send(8'h07, 1'b0, 1'b0);
    check("t4_stall_data7", win_if.data_in, 32'h01020304);
    check("t4_no_ovf_yet", {31'b0, overflow}, 32'd0);
    send(8'h08, 1'b0, 1'b1);
    idle(1);
    check("t4_ovf_set", {31'b0, overflow}, 32'd1);
    check("t4_stall_valid", {31'b0, win_if.win_valid}, 32'd1);
    check("t4_stall_data", win_if.data_in, 32'h01020304);
    check("t4_stall_last", {31'b0, win_if.win_last}, 32'd0);
    ovf_clr = 1'b1;
    idle(1);
    ovf_clr = 1'b0;
    check("t4_ovf_clr", {31'b0, overflow}, 32'd0);
    win_if.win_ready = 1'b1;
    idle(6);
    check("t4_count", got_data.size(), 32'd4);
    expect_win("t4_w0", 0, 32'h01020304, 1'b0);
    expect_win("t4_w1", 1, 32'h02030405, 1'b0);
    expect_win("t4_w2", 2, 32'h03040506, 1'b0);
    expect_win("t4_w3", 3, 32'h04050607, 1'b0);
    check("t4_empty_valid", {31'b0, win_if.win_valid}, 32'd0);
    check("t4_empty_hold", win_if.data_in, 32'h04050607);

    // 5: sop mid-packet abandons the first packet
    clear_got();
    send(8'h10, 1'b1, 1'b0);
    send(8'h11, 1'b0, 1'b0);
    send(8'h12, 1'b0, 1'b0);
    send(8'h13, 1'b0, 1'b0);
    send(8'h14, 1'b0, 1'b0);
    send(8'h15, 1'b0, 1'b0);
    send(8'h20, 1'b1, 1'b0);
    send(8'h21, 1'b0, 1'b0);
    send(8'h22, 1'b0, 1'b1);
    idle(4);
    check("t5_count", got_data.size(), 32'd4);
    expect_win("t5_w0", 0, 32'h10111213, 1'b0);
    expect_win("t5_w1", 1, 32'h11121314, 1'b0);
    expect_win("t5_w2", 2, 32'h12131415, 1'b0);
    expect_win("t5_w3", 3, 32'h00202122, 1'b1);
`ifdef FEEDER_BYTE_OFFSET_EN
    check("t5_off2", {16'b0, got_off[2]}, 32'd5);
    check("t5_off3", {16'b0, got_off[3]}, 32'd2);
`endif

    // 6: reset with windows queued, then a clean packet
    win_if.win_ready = 1'b0;
    clear_got();
    send(8'hA1, 1'b1, 1'b0);
    send(8'hA2, 1'b0, 1'b0);
    send(8'hA3, 1'b0, 1'b0);
    send(8'hA4, 1'b0, 1'b0);
    send(8'hA5, 1'b0, 1'b0);
    send(8'hA6, 1'b0, 1'b0);
    idle(1);
    check("t6_queued_valid", {31'b0, win_if.win_valid}, 32'd1);
    check("t6_queued_data", win_if.data_in, 32'hA1A2A3A4);
    rst = 1'b1;
    idle(1);
    check("t6_rst_valid", {31'b0, win_if.win_valid}, 32'd0);
    check("t6_rst_data", win_if.data_in, 32'h0);
    rst = 1'b0;
    win_if.win_ready = 1'b1;
    clear_got();
    send(8'hC0, 1'b0, 1'b0);   // no sop: ignored in IDLE
    send(8'hB1, 1'b1, 1'b0);
    send(8'hB2, 1'b0, 1'b0);
    send(8'hB3, 1'b0, 1'b0);
    send(8'hB4, 1'b0, 1'b0);
    send(8'hB5, 1'b0, 1'b1);
    idle(4);
    check("t6_count", got_data.size(), 32'd2);
    expect_win("t6_w0", 0, 32'hB1B2B3B4, 1'b0);
    expect_win("t6_w1", 1, 32'hB2B3B4B5, 1'b1);
`ifdef FEEDER_BYTE_OFFSET_EN
    check("t6_off0", {16'b0, got_off[0]}, 32'd3);
    check("t6_off1", {16'b0, got_off[1]}, 32'd4);
`endif

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
